// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser chain, per-channel rise/fall/both pulse,
// saturating event counters. Define MULTI_EDGE_STICKY_EN to add sticky status and irq.
module multi_edge_detector #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [2*WIDTH-1:0]       mode,
   input  logic [WIDTH-1:0]         cnt_clr,
   output logic [WIDTH-1:0]         level_sync,
   output logic [WIDTH-1:0]         edge_pulse,
   output logic [WIDTH*CNT_W-1:0]   edge_count
`ifdef MULTI_EDGE_STICKY_EN
   ,
   input  logic [WIDTH-1:0]         status_clr,
   output logic [WIDTH-1:0]         status,
   output logic                     irq
`endif
);

   localparam int                  MASK_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [MASK_W-1:0]   MASK_DONE = MASK_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  hist_q, hist_d;
   logic [MASK_W-1:0]                 mask_cnt_q, mask_cnt_d;
   logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic                              mask_active;
   logic [WIDTH-1:0]                  rise, fall, pulse;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = data_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // The mask covers the chain fill after reset so a level held through reset never pulses.
   always_comb begin
      mask_active = (mask_cnt_q != MASK_DONE);
      mask_cnt_d  = mask_cnt_q;
      if (mask_active) begin
         mask_cnt_d = mask_cnt_q + MASK_W'(1);
      end
   end

   always_comb begin
      rise  = sync_q[SYNC_STAGES-1] & ~hist_q;
      fall  = ~sync_q[SYNC_STAGES-1] & hist_q;
      pulse = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pulse[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
      end
      if (mask_active) begin
         pulse = '0;
      end
   end

   // A clear coinciding with a pulse keeps that pulse as the first new event.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt_clr[i]) begin
            cnt_d[i] = CNT_W'(pulse[i]);
         end else if (pulse[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         hist_q     <= '0;
         mask_cnt_q <= '0;
         cnt_q      <= '0;
      end else begin
         sync_q     <= sync_d;
         hist_q     <= hist_d;
         mask_cnt_q <= mask_cnt_d;
         cnt_q      <= cnt_d;
      end
   end

   assign level_sync = sync_q[SYNC_STAGES-1];
   assign edge_pulse = pulse;
   assign edge_count = cnt_q;

`ifdef MULTI_EDGE_STICKY_EN
   logic [WIDTH-1:0] status_q, status_d;
   logic             irq_q, irq_d;

   // Set wins over a same-cycle clear; irq tracks the next status value.
   always_comb begin
      status_d = (status_q & ~status_clr) | pulse;
      irq_d    = |status_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         irq_q    <= irq_d;
      end
   end

   assign status = status_q;
   assign irq    = irq_q;
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed table, corner sequences and random traffic
// checked every cycle against a sample-history reference model.
module tb_multi_edge_detector;

   localparam int W = 4;
   localparam int S = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   data_in;
   logic [2*W-1:0] mode;
   logic [W-1:0]   cnt_clr;
   logic [W-1:0]   level_sync, edge_pulse;
   logic [W*8-1:0] edge_count;
   logic [W-1:0]   level_sync2, edge_pulse2;
   logic [W*2-1:0] edge_count2;
`ifdef MULTI_EDGE_STICKY_EN
   logic [W-1:0]   status_clr;
   logic [W-1:0]   status, status2;
   logic           irq, irq2;
   logic [W-1:0]   m_status;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] samp[$];
   int           n_edges;
   logic [7:0]   m_cnt8[W];
   logic [1:0]   m_cnt2[W];

   multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .cnt_clr(cnt_clr),
      .level_sync(level_sync), .edge_pulse(edge_pulse), .edge_count(edge_count)
`ifdef MULTI_EDGE_STICKY_EN
      , .status_clr(status_clr), .status(status), .irq(irq)
`endif
   );

   multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .cnt_clr(cnt_clr),
      .level_sync(level_sync2), .edge_pulse(edge_pulse2), .edge_count(edge_count2)
`ifdef MULTI_EDGE_STICKY_EN
      , .status_clr(status_clr), .status(status2), .irq(irq2)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Synchronised level seen after n_edges clean edges is the input sampled S-1 edges earlier.
   function automatic logic [W-1:0] model_level(input int back);
      int idx;
      idx = n_edges - S - back;
      return (idx >= 0) ? samp[idx] : '0;
   endfunction

   function automatic logic [W-1:0] model_pulse();
      logic [W-1:0] lvl, prv, r;
      lvl = model_level(0);
      prv = model_level(1);
      r   = '0;
      if (n_edges >= S + 1) begin
         for (int i = 0; i < W; i++) begin
            case (mode[2*i +: 2])
               2'b01:   r[i] = lvl[i] & ~prv[i];
               2'b10:   r[i] = ~lvl[i] & prv[i];
               2'b11:   r[i] = lvl[i] ^ prv[i];
               default: r[i] = 1'b0;
            endcase
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] pack8();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < W; i++) v[8*i +: 8] = m_cnt8[i];
      return v;
   endfunction

   function automatic logic [31:0] pack2();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < W; i++) v[2*i +: 2] = m_cnt2[i];
      return v;
   endfunction

   task automatic model_update();
      logic [W-1:0] p;
      if (reset) begin
         samp.delete();
         n_edges = 0;
         for (int i = 0; i < W; i++) begin
            m_cnt8[i] = '0;
            m_cnt2[i] = '0;
         end
`ifdef MULTI_EDGE_STICKY_EN
         m_status = '0;
`endif
      end else begin
         p = model_pulse();
         for (int i = 0; i < W; i++) begin
            if (cnt_clr[i]) begin
               m_cnt8[i] = {7'd0, p[i]};
               m_cnt2[i] = {1'b0, p[i]};
            end else if (p[i]) begin
               if (m_cnt8[i] != 8'hFF) m_cnt8[i] = m_cnt8[i] + 8'd1;
               if (m_cnt2[i] != 2'h3)  m_cnt2[i] = m_cnt2[i] + 2'd1;
            end
         end
`ifdef MULTI_EDGE_STICKY_EN
         m_status = (m_status & ~status_clr) | p;
`endif
         samp.push_back(data_in);
         n_edges++;
      end
   endtask

   task automatic model_check();
      check("level_sync", 32'(level_sync), 32'(model_level(0)));
      check("edge_pulse", 32'(edge_pulse), 32'(model_pulse()));
      check("edge_count", edge_count, pack8());
      check("edge_pulse_sat", 32'(edge_pulse2), 32'(model_pulse()));
      check("edge_count_sat", 32'(edge_count2), pack2());
`ifdef MULTI_EDGE_STICKY_EN
      check("status", 32'(status), 32'(m_status));
      check("irq", 32'(irq), 32'(|m_status));
`endif
   endtask

   task automatic tick_check();
      @(negedge clk);
      model_check();
   endtask

   task automatic tick_edge();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cycle();
      tick_check();
      tick_edge();
   endtask

   task automatic run(input int k);
      for (int j = 0; j < k; j++) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] data;
      logic       chk;
      logic [3:0] exp_level;
      logic [3:0] exp_pulse;
      logic [7:0] exp_cnt0;
   } vec_t;

   vec_t tbl[11];
   logic [1:0] sat_exp[5];

   initial begin
      tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 8'd0};
      tbl[1]  = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 8'd0};
      tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 8'd0};
      tbl[3]  = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 8'd0};
      tbl[4]  = '{1'b0, 4'h1, 1'b1, 4'h0, 4'h0, 8'd0};
      tbl[5]  = '{1'b0, 4'h1, 1'b1, 4'h0, 4'h0, 8'd0};
      tbl[6]  = '{1'b0, 4'h1, 1'b1, 4'h1, 4'h1, 8'd0};
      tbl[7]  = '{1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 8'd1};
      tbl[8]  = '{1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 8'd1};
      tbl[9]  = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 8'd1};
      tbl[10] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 8'd1};
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

      reset   = 1'b1;
      data_in = 4'hF;
      mode    = 8'hFF;
      cnt_clr = '0;
`ifdef MULTI_EDGE_STICKY_EN
      status_clr = '0;
`endif
      @(posedge clk);
      model_update();
      #1;

      // Level held high through reset release, all channels in both-edge mode.
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("startup_no_pulse", 32'(edge_pulse), 32'h0);
         if (i == 1) check("startup_level", 32'(level_sync), 32'hF);
      end
      check("startup_count", edge_count, 32'h0);

      // Channel 0 rise-only: one pulse on the rise, none on the fall.
      mode = 8'h01;
      for (int r = 0; r < 11; r++) begin
         reset   = tbl[r].rst;
         data_in = tbl[r].data;
         tick_check();
         if (tbl[r].chk) begin
            check("tbl_level", 32'(level_sync), 32'(tbl[r].exp_level));
            check("tbl_pulse", 32'(edge_pulse), 32'(tbl[r].exp_pulse));
            check("tbl_cnt0", 32'(edge_count[7:0]), 32'(tbl[r].exp_cnt0));
         end
         tick_edge();
      end
      reset = 1'b0;

      // Shared waveform: ch1 fall-only, ch2 both, ch0/ch3 off.
      data_in = '0;
      mode    = 8'h38;
      do_reset();
      run(S + 1);
      for (int p = 0; p < 3; p++) begin
         data_in = 4'hE; run(3);
         data_in = 4'h0; run(3);
      end
      run(S + 2);
      check("toggle_counts", edge_count, 32'h0006_0300);
      check("toggle_counts_sat", 32'(edge_count2), 32'h3C);

      // Saturation on the 2-bit counter, then clear coinciding with a pulse.
      mode = 8'h01;
      do_reset();
      run(S + 1);
      for (int k = 0; k < 5; k++) begin
         data_in = 4'h1; run(3);
         data_in = 4'h0; run(3);
         check("sat_seq", 32'(edge_count2[1:0]), 32'(sat_exp[k]));
      end
      check("count5", 32'(edge_count[7:0]), 32'd5);
      data_in = 4'h1;
      cycle();
      cycle();
      check("clr_pulse_present", 32'(edge_pulse[0]), 32'd1);
      cnt_clr = 4'h1;
      cycle();
      cnt_clr = 4'h0;
      check("clr_with_pulse", 32'(edge_count[7:0]), 32'd1);
      check("clr_with_pulse_sat", 32'(edge_count2[1:0]), 32'd1);
      cnt_clr = 4'h1;
      cycle();
      cnt_clr = 4'h0;
      check("clr_alone", 32'(edge_count[7:0]), 32'd0);
      data_in = 4'h0;
      run(4);

`ifdef MULTI_EDGE_STICKY_EN
      mode = 8'hFF;
      do_reset();
      run(S + 1);
      data_in = 4'h4;
      run(3);
      check("sticky_set", 32'(status), 32'h4);
      check("sticky_irq", 32'(irq), 32'd1);
      data_in = 4'h0;
      run(2);
      status_clr = 4'h4;
      cycle();
      status_clr = 4'h0;
      check("sticky_set_wins", 32'(status), 32'h4);
      status_clr = 4'h4;
      cycle();
      status_clr = 4'h0;
      check("sticky_clear", 32'(status), 32'h0);
      check("sticky_irq_clear", 32'(irq), 32'd0);
`endif

      // Reset with count 5 on ch0 and a rise sitting in the synchroniser.
      mode = 8'h01;
      data_in = 4'h0;
      do_reset();
      run(S + 1);
      for (int k = 0; k < 5; k++) begin
         data_in = 4'h1; run(3);
         data_in = 4'h0; run(3);
      end
      check("pre_reset_count", 32'(edge_count[7:0]), 32'd5);
      data_in = 4'h1;
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("mid_reset_level", 32'(level_sync), 32'h0);
      check("mid_reset_pulse", 32'(edge_pulse), 32'h0);
      check("mid_reset_count", edge_count, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("mid_reset_mask", 32'(edge_pulse), 32'h0);
      end

      // Random traffic against the reference model.
      for (int c = 0; c < 1500; c++) begin
         reset   = ($urandom_range(0, 299) == 0);
         data_in = W'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
         cnt_clr = W'($urandom_range(0, 19) == 0 ? $urandom : 0);
`ifdef MULTI_EDGE_STICKY_EN
         status_clr = W'($urandom_range(0, 7) == 0 ? $urandom : 0);
`endif
         cycle();
      end
      reset = 1'b0;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
